cbs_bn_silu_stage: RTL and testbench

- Downstream neighbour of the dual-output CBS convolution stage. It consumes each pair of signed 16-bit conv results and applies a folded BatchNorm (scale, shift, bias), then a hard-SiLU approximation.
- It emits activated pairs ready for the layer RAM write-back.
- The datapath is a 3-stage pipeline with valid/ready flow control, a config port, and a row-pair counter that flags the last pair of each output row.

---
 rtl/cbs_pkg.sv | 23 ++
 rtl/bn_silu_lane.sv | 69 ++++++
 rtl/cbs_bn_silu_stage.sv | 104 ++++++++++
 tb/tb_cbs_bn_silu_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbs_pkg.sv
// Shared fixed-point constants and helpers for the CBS activation stages.
// Activations use FRAC fractional bits; hard-SiLU divides by 6 as *43 >> 8.
package cbs_pkg;

  localparam int FRAC        = 8;
  localparam int ACT_ONE     = 1 << FRAC;
  localparam int ACT_THREE   = 3 * ACT_ONE;
  localparam int SIXTH_NUM   = 43;
  localparam int SIXTH_SHIFT = 8;

  localparam logic signed [15:0] SAT16_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT16_MIN = 16'sh8000;

  function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
    if (v > 33'sd32767)
      return SAT16_MAX;
    else if (v < -33'sd32768)
      return SAT16_MIN;
    else
      return 16'(v);
  endfunction

endpackage

// File: rtl/bn_silu_lane.sv
// One lane of the folded BatchNorm + hard-SiLU pipeline (S1 scale, S2 bias/sat, S3 SiLU).
// All three stages advance together on i_en; the control path lives in the top.
module bn_silu_lane
  import cbs_pkg::*;
#(
  parameter int SCALE_SHIFT = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic signed [15:0] i_conv,
  input  logic signed [15:0] i_scale,
  input  logic signed [15:0] i_bias,
  output logic signed [15:0] o_act
);

  localparam logic signed [15:0] L_POS_THREE = 16'(ACT_THREE);
  localparam logic signed [15:0] L_NEG_THREE = 16'(-ACT_THREE);
  localparam int                 L_SILU_SHR  = FRAC + SIXTH_SHIFT;

  logic signed [31:0] w_prod;
  logic signed [31:0] w_shifted;
  logic signed [32:0] w_sum;
  logic signed [15:0] w_y;
  logic signed [16:0] w_t;
  logic signed [31:0] w_poly;
  logic signed [15:0] w_silu;

  logic signed [31:0] r_s1;
  logic signed [15:0] r_y;
  logic signed [16:0] r_t;
  logic signed [15:0] r_act;

  assign w_prod    = i_conv * i_scale;
  assign w_shifted = w_prod >>> SCALE_SHIFT;
  assign w_sum     = 33'(r_s1) + 33'(i_bias);
  assign w_y       = sat16(w_sum);
  assign w_t       = 17'(w_y) + 17'(ACT_THREE);

  // |y| < 3*ONE and 0 < t < 6*ONE inside the cubic region, so 32 bits cannot overflow.
  assign w_poly = 32'(r_y) * 32'(r_t) * 32'(SIXTH_NUM);

  always_comb begin
    w_silu = 16'sd0;
    if (r_y <= L_NEG_THREE)
      w_silu = 16'sd0;
    else if (r_y >= L_POS_THREE)
      w_silu = r_y;
    else
      w_silu = 16'(w_poly >>> L_SILU_SHR);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1  <= '0;
      r_y   <= '0;
      r_t   <= '0;
      r_act <= '0;
    end else if (i_en) begin
      r_s1  <= w_shifted;
      r_y   <= w_y;
      r_t   <= w_t;
      r_act <= w_silu;
    end
  end

  assign o_act = r_act;

endmodule

// File: rtl/cbs_bn_silu_stage.sv
// BN + hard-SiLU stage for dual-lane conv pairs: valid chain, global-stall handshake,
// scale/bias config and a row-pair counter that flags the last pair of each row.
module cbs_bn_silu_stage
  import cbs_pkg::*;
#(
  parameter int SCALE_SHIFT = 8,
  parameter int OUT_PAIRS   = 320
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic signed [15:0] i_conv_a,
  input  logic signed [15:0] i_conv_b,
  input  logic               i_cfg_we,
  input  logic signed [15:0] i_cfg_scale,
  input  logic signed [15:0] i_cfg_bias,
  output logic               o_cfg_busy,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic signed [15:0] o_act_a,
  output logic signed [15:0] o_act_b,
  output logic               o_out_last
);

  localparam int                 CW        = (OUT_PAIRS > 1) ? $clog2(OUT_PAIRS) : 1;
  localparam logic [CW-1:0]      LAST_CNT  = CW'(OUT_PAIRS - 1);
  localparam logic signed [15:0] SCALE_ONE = 16'(1 << SCALE_SHIFT);

  logic               r_v1, r_v2, r_v3;
  logic signed [15:0] r_scale;
  logic signed [15:0] r_bias;
  logic [CW-1:0]      r_cnt;

  logic               w_advance;
  logic               w_busy;
  logic               w_cfg_load;
  logic               w_xfer;
  logic signed [15:0] w_scale_eff;

  assign w_advance  = !r_v3 || i_out_ready;
  assign w_busy     = r_v1 || r_v2 || r_v3;
  assign w_cfg_load = i_cfg_we && !w_busy;
  assign w_xfer     = r_v3 && i_out_ready;

  // A pair entering with the config write already uses the new scale; bias is
  // consumed one stage later, by which time r_bias holds the new value.
  assign w_scale_eff = w_cfg_load ? i_cfg_scale : r_scale;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_advance) begin
      r_v1 <= i_in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scale <= SCALE_ONE;
      r_bias  <= '0;
    end else if (w_cfg_load) begin
      r_scale <= i_cfg_scale;
      r_bias  <= i_cfg_bias;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_cnt <= '0;
    else if (w_xfer)
      r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + CW'(1);
  end

  bn_silu_lane #(.SCALE_SHIFT(SCALE_SHIFT)) u_lane_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_advance),
    .i_conv  (i_conv_a),
    .i_scale (w_scale_eff),
    .i_bias  (r_bias),
    .o_act   (o_act_a)
  );

  bn_silu_lane #(.SCALE_SHIFT(SCALE_SHIFT)) u_lane_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_advance),
    .i_conv  (i_conv_b),
    .i_scale (w_scale_eff),
    .i_bias  (r_bias),
    .o_act   (o_act_b)
  );

  assign o_in_ready  = w_advance;
  assign o_cfg_busy  = w_busy;
  assign o_out_valid = r_v3;
  assign o_out_last  = r_v3 && (r_cnt == LAST_CNT);

endmodule

// File: tb/tb_cbs_bn_silu_stage.sv
// Scoreboard bench for cbs_bn_silu_stage: directed pairs with hand-computed
// activations; an independent monitor pops and compares on every output transfer.
module tb_cbs_bn_silu_stage;

  localparam int OUT_PAIRS = 4;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_in_valid;
  logic               o_in_ready;
  logic signed [15:0] i_conv_a, i_conv_b;
  logic               i_cfg_we;
  logic signed [15:0] i_cfg_scale, i_cfg_bias;
  logic               o_cfg_busy;
  logic               o_out_valid;
  logic               i_out_ready = 1'b1;
  logic signed [15:0] o_act_a, o_act_b;
  logic               o_out_last;

  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic               last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int stall_lo = 1;
  int stall_hi = 0;
  int first_xfer_cyc = -1;
  int last_xfer_cyc  = 0;
  int base_cyc;

  logic               prev_stall = 1'b0;
  logic signed [15:0] hold_a, hold_b;
  logic               hold_last;

  cbs_bn_silu_stage #(.SCALE_SHIFT(8), .OUT_PAIRS(OUT_PAIRS)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_conv_a    (i_conv_a),
    .i_conv_b    (i_conv_b),
    .i_cfg_we    (i_cfg_we),
    .i_cfg_scale (i_cfg_scale),
    .i_cfg_bias  (i_cfg_bias),
    .o_cfg_busy  (o_cfg_busy),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_act_a     (o_act_a),
    .o_act_b     (o_act_b),
    .o_out_last  (o_out_last)
  );

  always #5 i_clk = ~i_clk;

  // Cycle counter and consumer backpressure window.
  initial forever begin
    @(posedge i_clk);
    cyc++;
    #1;
    i_out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
  end

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every transfer against the scoreboard, and holds during stalls.
  initial forever begin
    @(negedge i_clk);
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(o_out_valid), 32'(1'b1));
        check("hold_act_a", o_act_a, hold_a);
        check("hold_act_b", o_act_b, hold_b);
        check("hold_last",  32'(o_out_last), 32'(hold_last));
      end
      if (o_out_valid && i_out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output act_a=%0d act_b=%0d expected=none", o_act_a, o_act_b);
        end else begin
          mon_e = sb.pop_front();
          check("act_a", o_act_a, mon_e.a);
          check("act_b", o_act_b, mon_e.b);
          check("out_last", 32'(o_out_last), 32'(mon_e.last));
        end
        if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        prev_stall = 1'b0;
      end else if (o_out_valid) begin
        prev_stall = 1'b1;
        hold_a     = o_act_a;
        hold_b     = o_act_b;
        hold_last  = o_out_last;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Presents one pair until accepted; returns just after the accepting edge.
  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                      input logic signed [15:0] ea, input logic signed [15:0] eb,
                      input logic el);
    int   tries = 0;
    logic acc   = 1'b0;
    exp_t e;
    i_in_valid = 1'b1;
    i_conv_a   = a;
    i_conv_b   = b;
    while (!acc) begin
      @(negedge i_clk);
      acc = o_in_ready;
      @(posedge i_clk);
      if (acc) begin
        e.a = ea; e.b = eb; e.last = el;
        sb.push_back(e);
      end
      #1;
      tries++;
      if (!acc && tries > 30) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout in_ready=%0b expected=1", o_in_ready);
        acc = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    i_in_valid = 1'b0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge i_clk);
      n++;
    end
    repeat (2) @(posedge i_clk);
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic cfg_load(input logic signed [15:0] s, input logic signed [15:0] bias);
    i_cfg_we    = 1'b1;
    i_cfg_scale = s;
    i_cfg_bias  = bias;
    @(posedge i_clk);
    #1;
    i_cfg_we = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_in_valid = 1'b0; i_conv_a = '0; i_conv_b = '0;
    i_cfg_we = 1'b0; i_cfg_scale = '0; i_cfg_bias = '0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_out_valid", 32'(o_out_valid), 0);
    check("rst_act_a", o_act_a, 0);
    check("rst_act_b", o_act_b, 0);
    check("rst_out_last", 32'(o_out_last), 0);
    check("rst_in_ready", 32'(o_in_ready), 1);
    check("rst_cfg_busy", 32'(o_cfg_busy), 0);
    @(posedge i_clk);
    #1;

    // Identity config out of reset.
    base_cyc = cyc;
    first_xfer_cyc = -1;
    send(16'sd1024, -16'sd1024, 16'sd1024, 16'sd0,   1'b0);
    send(16'sd256,  -16'sd256,  16'sd172,  -16'sd86, 1'b0);
    send(16'sd0,    16'sd768,   16'sd0,    16'sd768, 1'b0);
    drain();
    check("latency_first", first_xfer_cyc - base_cyc, 3);

    // Bias -300 loaded in the same cycle as the pair: y = -44 -> -21.
    i_cfg_we = 1'b1; i_cfg_scale = 16'sd256; i_cfg_bias = -16'sd300;
    send(16'sd256, 16'sd256, -16'sd21, -16'sd21, 1'b1);
    i_cfg_we = 1'b0;
    drain();

    // Scale 512 saturates both lanes.
    i_cfg_we = 1'b1; i_cfg_scale = 16'sd512; i_cfg_bias = 16'sd0;
    send(16'sd32767, 16'sh8000, 16'sd32767, 16'sd0, 1'b0);
    i_cfg_we = 1'b0;
    drain();

    // Backpressure: consumer stalls cycles 4..7 of the stream.
    cfg_load(16'sd256, 16'sd0);
    base_cyc = cyc;
    stall_lo = base_cyc + 4;
    stall_hi = base_cyc + 7;
    fork
      begin
        send(16'sd1000, -16'sd1000, 16'sd1000, 16'sd0,    1'b0);
        send(16'sd800,  16'sd300,   16'sd800,  16'sd210,  1'b0);
        send(-16'sd100, 16'sd5000,  -16'sd44,  16'sd5000, 1'b1);
        send(16'sd768,  -16'sd768,  16'sd768,  16'sd0,    1'b0);
        send(16'sd512,  16'sd767,   16'sd430,  16'sd772,  1'b0);
      end
      begin
        while (cyc < base_cyc + 4) @(negedge i_clk);
        for (int k = 0; k < 4; k++) begin
          check("stall_in_ready", 32'(o_in_ready), 0);
          check("stall_out_valid", 32'(o_out_valid), 1);
          @(negedge i_clk);
        end
      end
    join
    drain();
    check("stall_latency_last", last_xfer_cyc - base_cyc, 11);
    stall_lo = 1;
    stall_hi = 0;

    // Row wrap: restart counter, 9 pairs, config write while busy must be ignored.
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    sb.delete();
    fork
      begin
        for (int i = 0; i < 9; i++)
          send(16'(1000 + 100 * i), 16'sd256, 16'(1000 + 100 * i), 16'sd172, (i % 4) == 3);
      end
      begin
        repeat (2) @(posedge i_clk);
        #1;
        i_cfg_we = 1'b1; i_cfg_scale = 16'sd0; i_cfg_bias = 16'sd1000;
        @(negedge i_clk);
        check("cfg_busy_high", 32'(o_cfg_busy), 1);
        @(posedge i_clk);
        #1;
        i_cfg_we = 1'b0;
      end
    join
    drain();

    // Mid-stream reset discards in-flight pairs and restores identity config.
    cfg_load(16'sd512, 16'sd100);
    send(16'sd1000, 16'sd1000, 16'sd0, 16'sd0, 1'b0);
    send(16'sd2000, 16'sd2000, 16'sd0, 16'sd0, 1'b0);
    i_in_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    sb.delete();
    @(negedge i_clk);
    check("midrst_out_valid", 32'(o_out_valid), 0);
    check("midrst_cfg_busy", 32'(o_cfg_busy), 0);
    check("midrst_out_last", 32'(o_out_last), 0);
    repeat (4) @(posedge i_clk);
    #1;
    send(16'sd900,  -16'sd900, 16'sd900, 16'sd0,    1'b0);
    send(16'sd300,  16'sd1200, 16'sd210, 16'sd1200, 1'b0);
    send(-16'sd100, 16'sd768,  -16'sd44, 16'sd768,  1'b0);
    send(16'sd512,  -16'sd768, 16'sd430, 16'sd0,    1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
